// File: rtl/leg_instr_assembler.sv
// leg_instr_assembler
//   Collects the four-byte LEG instruction (opcode, arg1, arg2, dest) one byte
//   per accepted transfer. Presents it through a one-deep output register with
//   a valid/ready handshake. The low nibble of dest is broken out as four
//   select lines for the downstream register-select decoder.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   in_byte/in_valid/in_ready   upstream byte stream
//   flush             synchronous discard of partial and held instruction
//   out_valid/out_ready         output handshake
//   opcode, arg1, arg2, dest    assembled instruction fields
//   imm1, imm2        opcode immediate flags (top two opcode bits)
//   dest_1..dest_8    dest[0]..dest[3], weighted decoder select lines
//   byte_count        index of the next byte to be accepted
//
// Control state (byte_count x out_valid, all 8 combinations legal)
//   byte_count | out_valid | meaning
//   0..2       | 0         | gathering bytes, output empty
//   0..2       | 1         | gathering bytes, previous instruction held
//   3          | 0         | completing byte will load at once
//   3          | 1         | completing byte waits for the consumer to drain

module leg_instr_assembler #(
  parameter int UUID       = 0,
  parameter     NAME       = "",
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BYTE_WIDTH-1:0] in_byte,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BYTE_WIDTH-1:0] opcode,
  output logic [BYTE_WIDTH-1:0] arg1,
  output logic [BYTE_WIDTH-1:0] arg2,
  output logic [BYTE_WIDTH-1:0] dest,
  output logic                  imm1,
  output logic                  imm2,
  output logic                  dest_1,
  output logic                  dest_2,
  output logic                  dest_4,
  output logic                  dest_8,
  output logic [1:0]            byte_count
);

  // dest must carry at least the four decoder select bits; a negative UUID
  // would corrupt the XOR-derived child identifiers.
  if (BYTE_WIDTH < 4 || UUID < 0) begin : g_param_check
    $error("leg_instr_assembler %s: BYTE_WIDTH must be >= 4 and UUID >= 0", NAME);
  end

  logic [BYTE_WIDTH-1:0] s0, s1, s2;
  logic [1:0]            byte_count_nxt;
  logic                  out_valid_nxt;
  logic                  accept;
  logic                  drain;
  logic                  complete;

  always_comb begin
    // Only the completing byte has to wait for room in the output register.
    in_ready       = !rst && !flush && (byte_count != 2'd3 || !out_valid || out_ready);
    accept         = in_valid && in_ready;
    drain          = out_valid && out_ready;
    complete       = accept && (byte_count == 2'd3);
    byte_count_nxt = byte_count;
    out_valid_nxt  = out_valid;
    if (flush) begin
      byte_count_nxt = 2'd0;
      out_valid_nxt  = 1'b0;
    end else begin
      if (accept)
        byte_count_nxt = byte_count + 2'd1;
      // A load on the drain edge keeps out_valid high: no bubble.
      if (complete)
        out_valid_nxt = 1'b1;
      else if (drain)
        out_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_count <= 2'd0;
      out_valid  <= 1'b0;
    end else begin
      byte_count <= byte_count_nxt;
      out_valid  <= out_valid_nxt;
    end
  end

  // Flush leaves the field registers alone; accept is already blocked by it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0     <= '0;
      s1     <= '0;
      s2     <= '0;
      opcode <= '0;
      arg1   <= '0;
      arg2   <= '0;
      dest   <= '0;
    end else if (accept) begin
      case (byte_count)
        2'd0: s0 <= in_byte;
        2'd1: s1 <= in_byte;
        2'd2: s2 <= in_byte;
        default: begin
          opcode <= s0;
          arg1   <= s1;
          arg2   <= s2;
          dest   <= in_byte;
        end
      endcase
    end
  end

  // Derived bits come from the output registers only, so they stay stable
  // while the output is stalled and never expose partial staging data.
  assign imm1   = opcode[BYTE_WIDTH-1];
  assign imm2   = opcode[BYTE_WIDTH-2];
  assign dest_1 = dest[0];
  assign dest_2 = dest[1];
  assign dest_4 = dest[2];
  assign dest_8 = dest[3];

endmodule

// File: tb/tb_leg_instr_assembler.sv
module tb_leg_instr_assembler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_byte = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       flush = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] opcode, arg1, arg2, dest;
  logic       imm1, imm2, dest_1, dest_2, dest_4, dest_8;
  logic [1:0] byte_count;

  int n_cmp = 0;
  int n_err = 0;

  // bench model: bytes staged so far and completed instructions awaiting drain
  logic [7:0]  stg [3];
  int          exp_cnt = 0;
  logic [31:0] exp_q [$];

  leg_instr_assembler #(.UUID(0), .NAME("tb_asm"), .BYTE_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .opcode(opcode), .arg1(arg1), .arg2(arg2),
    .dest(dest), .imm1(imm1), .imm2(imm2), .dest_1(dest_1), .dest_2(dest_2),
    .dest_4(dest_4), .dest_8(dest_8), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drain monitor: a transfer seen at the negedge happens at the next posedge.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && !flush && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("instr", {opcode, arg1, arg2, dest}, e);
          chk("imm", {30'd0, imm1, imm2}, {30'd0, e[31], e[30]});
          chk("dest_lines", {28'd0, dest_8, dest_4, dest_2, dest_1}, {28'd0, e[3:0]});
        end
      end
    end
  end

  // Presents one byte, waits (bounded) for acceptance, returns #1 after the edge.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    in_valid = 1'b1;
    in_byte  = b;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("send_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      if (exp_cnt < 3) stg[exp_cnt] = b;
      else exp_q.push_back({stg[0], stg[1], stg[2], b});
      exp_cnt = (exp_cnt + 1) % 4;
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_instr(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // reset mid-stream
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_opcode", {24'd0, opcode}, 32'd0);
    out_ready = 1'b1;
    send_byte(8'hAA);
    send_byte(8'hBB);
    chk("cnt_before_rst", {30'd0, byte_count}, 32'd2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_cnt", {30'd0, byte_count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_valid2", {31'd0, out_valid}, 32'd0);
    exp_cnt = 0;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    send_instr(32'h00_01_02_05);
    chk("post_rst_opcode", {24'd0, opcode}, 32'h00);
    chk("post_rst_dest", {24'd0, dest}, 32'h05);
    chk("post_rst_lines", {28'd0, dest_8, dest_4, dest_2, dest_1}, 32'b0101);
    idle(2);

    // back-to-back stream
    send_instr(32'hC0_03_04_0F);
    chk("b2b1_imm", {30'd0, imm1, imm2}, 32'b11);
    chk("b2b1_lines", {28'd0, dest_8, dest_4, dest_2, dest_1}, 32'b1111);
    send_instr(32'h01_02_03_0A);
    chk("b2b2_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b2_dest", {24'd0, dest}, 32'h0A);
    chk("b2b2_lines", {28'd0, dest_8, dest_4, dest_2, dest_1}, 32'b1010);
    idle(2);

    // output stall, then drain and load on the same edge
    out_ready = 1'b0;
    send_instr(32'h41_11_22_06);
    send_byte(8'h82);
    send_byte(8'h33);
    send_byte(8'h44);
    chk("stall_cnt", {30'd0, byte_count}, 32'd3);
    in_valid = 1'b1;
    in_byte  = 8'h09;
    idle(3);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    chk("stall_fields", {opcode, arg1, arg2, dest}, 32'h41_11_22_06);
    chk("stall_lines", {28'd0, dest_8, dest_4, dest_2, dest_1}, 32'b0110);
    out_ready = 1'b1;
    send_byte(8'h09);
    chk("sim_valid", {31'd0, out_valid}, 32'd1);
    chk("sim_fields", {opcode, arg1, arg2, dest}, 32'h82_33_44_09);
    chk("sim_imm", {30'd0, imm1, imm2}, 32'b10);
    chk("sim_cnt", {30'd0, byte_count}, 32'd0);
    idle(2);

    // flush with a held instruction and two partial bytes
    out_ready = 1'b0;
    send_instr(32'h12_34_56_07);
    send_byte(8'h99);
    send_byte(8'h98);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'h97;
    @(negedge clk);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    exp_cnt  = 0;
    exp_q.delete();
    chk("flush_cnt", {30'd0, byte_count}, 32'd0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_fields", {opcode, arg1, arg2, dest}, 32'h12_34_56_07);
    out_ready = 1'b1;
    send_instr(32'h40_0A_0B_03);
    chk("post_flush", {opcode, arg1, arg2, dest}, 32'h40_0A_0B_03);
    idle(2);

    // wrap and sweep of every dest nibble
    for (int i = 0; i < 16; i++) begin
      logic [7:0] bs [4];
      bs[0] = 8'($urandom_range(0, 255));
      bs[1] = 8'($urandom_range(0, 255));
      bs[2] = 8'($urandom_range(0, 255));
      bs[3] = 8'(i);
      for (int j = 0; j < 4; j++) begin
        chk("sweep_cnt", {30'd0, byte_count}, 32'(j));
        send_byte(bs[j]);
      end
      chk("sweep_lines", {28'd0, dest_8, dest_4, dest_2, dest_1}, 32'(i));
    end
    idle(3);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
